dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-side memory responder for the pipelined ARM core: it answers the core's Memory-stage data port (write enable, address, write data) and returns read data in the same cycle. It holds a word-addressed data RAM plus a small memory-mapped I/O window with a cycle counter, a GPIO output register and an output FIFO drained through a valid/ready stream. It connects directly to the core's data port and to a downstream consumer such as a UART or testbench sink.

## Interface
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 8, output FIFO depth in 32-bit entries; power of 2, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- mem_write  in  1  write strobe from the core's Memory stage.
- addr  in  32  byte address from the core; bits [1:0] are ignored.
- write_data  in  32  store data.
- read_data  out  32  combinational read data for `addr`.
- gpio_out  out  32  GPIO register contents.
- out_valid  out  1  output FIFO is not empty.
- out_data  out  32  FIFO head entry. Only meaningful while out_valid=1.
- out_ready  in  1  consumer accepts the head entry this cycle.

## Operation
- The core presents `addr` every cycle, including for non-memory instructions. **Reads must have no side effects.** All state changes require mem_write=1 or a stream pop.
- Region select uses addr[31]:
  - 0 selects RAM. The word index is addr[log2(RAM_WORDS)+1:2]; higher address bits are ignored, so accesses alias and wrap.
  - 1 selects MMIO, decoded on addr[5:2].
- RAM behaviour:
  - Asynchronous read.
  - On mem_write=1, the word is written at the clock edge.
  - Contents are not cleared by reset.
- MMIO map (offsets from 0x8000_0000):
  - 0x00 CYCLE, read-only. 32-bit free-running counter that increments every cycle and wraps from 0xFFFF_FFFF to 0. Writes are ignored.
  - 0x04 GPIO, read/write. The write updates the register; a read returns the register value.
  - 0x08 FIFO_DATA, write-only. A write pushes write_data. Reads return 0.
  - 0x0C STATUS.
    - Read layout: [7:0] = occupancy count (zero-extended), [8] = full, [9] = empty, [10] = overflow (sticky), all other bits 0.
    - Writing with write_data[10]=1 clears overflow. Any other write has no effect.
  - Any other MMIO offset reads 0; writes to it are ignored.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Pop: out_valid & out_ready.
  - Push request: mem_write at FIFO_DATA.
  - The push is accepted when not full, or when a pop occurs in the same cycle.
  - When a push is rejected, the data is dropped and overflow is set to 1.
  - A simultaneous accepted push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No fall-through: data pushed into an empty FIFO appears on out_data/out_valid the next cycle.
  - Entries are presented strictly in push order.
- Overflow set and clear in the same cycle: the set wins.
- read_data always reflects the state before the current edge's update. A write and a read to the same location in one cycle returns the old value.

## Timing
- Reset values:
  - CYCLE = 0, GPIO = 0, gpio_out = 0.
  - FIFO empty, count = 0, pointers = 0, overflow = 0.
  - out_valid = 0.
  - read_data follows addr combinationally (for example, 0 when addr = 0x8000_0000).
- Read latency is 0 cycles (combinational), as the core registers read data into its Writeback stage at the next edge.
- Write latency is 1 edge. GPIO, RAM, FIFO and overflow updates are visible from the cycle after the mem_write cycle.
- CYCLE reads 0 in the first cycle after reset deasserts, then 1, 2, and so on.
- Reset asserted mid-operation immediately clears all MMIO and FIFO state; out_valid drops asynchronously. RAM is retained.
- out_data and out_valid come straight from registers/pointers: no combinational path from out_ready to out_valid.

## Test plan
- Reset, then run 5 idle cycles, then read 0x8000_0000 -> read_data=5. Read 0x8000_000C -> 0x0000_0200 (empty).
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and its alias 0x0000_0110 (RAM_WORDS=64) -> both return 0xDEADBEEF. Writes to 0x8000_0000 leave CYCLE counting.
- Write 0x0000_00A5 to 0x8000_0004 -> gpio_out=0xA5 from the next cycle; reading 0x8000_0004 returns 0xA5.
- With out_ready=0, push 1..9 to 0x8000_0008:
  - STATUS = 0x0000_0508 (count 8, full, overflow).
  - Then raise out_ready -> out_data sequence 1..8 on consecutive cycles, then out_valid=0.
  - Write 0x400 to STATUS -> overflow=0.
- FIFO full, out_ready=1, push 0x77 in the same cycle -> accepted, count stays 8, no overflow, 0x77 emerges last.
- Hold addr=0x8000_0008 with mem_write=0 for many cycles -> count unchanged and read_data=0 (no read side effects). Assert reset while the FIFO holds 3 entries -> out_valid=0 immediately; STATUS reads 0x200 after reset.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-side memory responder for the pipelined ARM core. It answers the core's
// Memory-stage data port with same-cycle (combinational) read data. Behind it
// sit a word-addressed data RAM and a small MMIO window. The window holds a
// free-running cycle counter, a GPIO output register, and an output FIFO that
// drains through a valid/ready stream.
//
// Address map (addr[31] selects the region):
//   0x0000_0000..  data RAM. The word index is addr[log2(RAM_WORDS)+1:2], and
//                  the higher bits alias.
//   0x8000_0000    CYCLE      (RO)  free-running 32-bit counter
//   0x8000_0004    GPIO       (RW)  drives gpio_out
//   0x8000_0008    FIFO_DATA  (WO)  a write pushes write_data; reads return 0
//   0x8000_000C    STATUS     (RW1C on bit 10)
//                  [7:0] count, [8] full, [9] empty, [10] overflow (sticky)
//   other offsets  read 0; writes are ignored
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high; clears MMIO/FIFO state, not RAM
//   mem_write   in   store strobe from the Memory stage
//   addr        in   byte address (bits [1:0] ignored)
//   write_data  in   store data
//   read_data   out  combinational read data for addr (pre-edge state)
//   gpio_out    out  GPIO register
//   out_valid   out  FIFO not empty
//   out_data    out  FIFO head entry
//   out_ready   in   consumer takes the head entry this cycle
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [31:0] gpio_out,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_GPIO   = 4'h1;
  localparam logic [3:0] OFF_FIFO   = 4'h2;
  localparam logic [3:0] OFF_STATUS = 4'h3;

  localparam int STATUS_OVF_BIT = 10;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic              is_mmio;
  logic [RAM_AW-1:0] ram_index;
  logic [3:0]        mmio_off;

  assign is_mmio   = addr[31];
  assign ram_index = addr[RAM_AW+1:2];
  assign mmio_off  = addr[5:2];

  // The byte-offset bits and the upper aliasing bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[30:6], addr[1:0]};

  logic ram_we;
  logic gpio_we;
  logic push_req;
  logic ovf_clear;

  assign ram_we    = mem_write & ~is_mmio;
  assign gpio_we   = mem_write & is_mmio & (mmio_off == OFF_GPIO);
  assign push_req  = mem_write & is_mmio & (mmio_off == OFF_FIFO);
  assign ovf_clear = mem_write & is_mmio & (mmio_off == OFF_STATUS)
                   & write_data[STATUS_OVF_BIT];

  // ---------------------------------------------------------------------------
  // Data RAM: asynchronous read, synchronous write. It has no reset, so
  // contents survive a core reset.
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_index] <= write_data;
    end
  end

  assign ram_rdata = ram[ram_index];

  // ---------------------------------------------------------------------------
  // Cycle counter and GPIO
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_count;
  logic [31:0] gpio_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_reg <= 32'd0;
    end else if (gpio_we) begin
      gpio_reg <= write_data;
    end
  end

  assign gpio_out = gpio_reg;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  logic full;
  logic empty;
  logic pop;
  logic push_ok;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // out_valid depends only on the count register, so a consumer that drives
  // out_ready from out_valid does not close a combinational loop.
  assign out_valid = ~empty;
  assign out_data  = fifo_mem[rd_ptr];

  assign pop = out_valid & out_ready;

  // When the FIFO is full, a pop in the same cycle frees the head slot. The
  // head slot is exactly where wr_ptr points (wr_ptr == rd_ptr when full), so
  // the push can take it. out_data is still read from that slot before the
  // edge, so the departing entry is not corrupted.
  assign push_ok = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The sticky overflow flag is set by a rejected push. A set takes priority
  // over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req & ~push_ok) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: this reflects the pre-edge state only, so reads never change
  // anything.
  // ---------------------------------------------------------------------------
  logic [7:0]  count_byte;
  logic [31:0] status_word;

  assign count_byte  = 8'(count);
  assign status_word = {21'd0, overflow, empty, full, count_byte};

  always_comb begin
    read_data = 32'd0;
    if (!is_mmio) begin
      read_data = ram_rdata;
    end else begin
      case (mmio_off)
        OFF_CYCLE:  read_data = cycle_count;
        OFF_GPIO:   read_data = gpio_reg;
        OFF_STATUS: read_data = status_word;
        default:    read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. The bench runs in four parts:
//   1. A directed table of per-cycle vectors. Each vector holds the inputs and
//      the expected outputs, and is applied straight after reset.
//   2. A hand-written sequence that asserts reset mid-operation. It checks
//      that the asynchronous clear happens and that RAM is retained.
//   3. A RAM fill, followed by randomized traffic. The traffic is checked
//      against a behavioural model that uses a queue for the FIFO and an
//      array for the RAM.
//   4. One summary line.
// Inputs change just after the falling edge. Outputs are sampled 1 time unit
// later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int RW = 64;
  localparam int FD = 8;

  localparam logic [31:0] A_CYC  = 32'h8000_0000;
  localparam logic [31:0] A_GPIO = 32'h8000_0004;
  localparam logic [31:0] A_FIFO = 32'h8000_0008;
  localparam logic [31:0] A_STAT = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] read_data;
  logic [31:0] gpio_out;
  logic        out_valid;
  logic [31:0] out_data;

  dmem_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .gpio_out   (gpio_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_ram [RW];
  logic [31:0] m_cycle;
  logic [31:0] m_gpio;
  logic [31:0] m_q [$];
  bit          m_ovf;

  function automatic int m_off(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] s;
    if (!a[31]) return m_ram[int'((a >> 2) % RW)];
    case (m_off(a))
      0: return m_cycle;
      1: return m_gpio;
      3: begin
        s = 32'(m_q.size());
        if (m_q.size() == FD) s = s | 32'h100;
        if (m_q.size() == 0)  s = s | 32'h200;
        if (m_ovf)            s = s | 32'h400;
        return s;
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_cycle = 0;
    m_gpio  = 0;
    m_q.delete();
    m_ovf   = 0;
  endtask

  task automatic m_step(input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input bit rdy);
    bit pop_now;
    bit push_req;
    bit accepted;
    pop_now  = (m_q.size() > 0) && rdy;
    push_req = we && a[31] && (m_off(a) == 2);
    accepted = push_req && ((m_q.size() < FD) || pop_now);
    if (pop_now) void'(m_q.pop_front());
    if (accepted) m_q.push_back(wd);
    if (push_req && !accepted) m_ovf = 1;
    else if (we && a[31] && m_off(a) == 3 && wd[10]) m_ovf = 0;
    if (we && a[31] && m_off(a) == 1) m_gpio = wd;
    if (we && !a[31]) m_ram[int'((a >> 2) % RW)] = wd;
    m_cycle = m_cycle + 1;
  endtask

  // ---------------------------------------------------------------------------
  // Drive / advance helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit rdy);
    mem_write  = we;
    addr       = a;
    write_data = wd;
    out_ready  = rdy;
    #1;
  endtask

  task automatic finish_cycle();
    m_step(mem_write, addr, write_data, out_ready);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    bit          rdy;
    bit          crd;  logic [31:0] erd;
    bit          cv;   bit          ev;
    bit          cd;   logic [31:0] ed;
    bit          cg;   logic [31:0] eg;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input bit rdy, input bit crd, input logic [31:0] erd,
                              input bit cv, input bit ev, input bit cd,
                              input logic [31:0] ed, input bit cg, input logic [31:0] eg);
    vec_t v;
    v.we = we;   v.a = a;     v.wd = wd;   v.rdy = rdy;
    v.crd = crd; v.erd = erd; v.cv = cv;   v.ev = ev;
    v.cd = cd;   v.ed = ed;   v.cg = cg;   v.eg = eg;
    tbl.push_back(v);
  endfunction

  task automatic build_table();
    // Reset state and CYCLE counting from 0.
    add(0, A_CYC, 0, 0, 1, 32'd0, 1, 0, 0, 0, 1, 32'd0);
    for (int k = 1; k <= 5; k++) add(0, A_CYC, 0, 0, 1, 32'(k), 0, 0, 0, 0, 0, 0);
    add(0, A_STAT, 0, 0, 1, 32'h200, 1, 0, 0, 0, 0, 0);
    // RAM write, read back, and aliasing.
    add(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    add(0, 32'h110, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    // A write to CYCLE is ignored.
    add(1, A_CYC, 32'h0001_2345, 0, 1, 32'd10, 0, 0, 0, 0, 0, 0);
    add(0, A_CYC, 0, 0, 1, 32'd11, 0, 0, 0, 0, 0, 0);
    // GPIO: the old value is seen during the write cycle, the new one after.
    add(1, A_GPIO, 32'hA5, 0, 1, 32'd0, 0, 0, 0, 0, 1, 32'd0);
    add(0, A_GPIO, 0, 0, 1, 32'hA5, 0, 0, 0, 0, 1, 32'hA5);
    // Push 1..9 with out_ready low; the ninth push overflows.
    for (int k = 1; k <= 9; k++)
      add(1, A_FIFO, 32'(k), 0, 1, 32'd0, 1, (k > 1), (k > 1), 32'd1, 0, 0);
    add(0, A_STAT, 0, 0, 1, 32'h508, 1, 1, 1, 32'd1, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, A_GPIO, 0, 1, 1, 32'hA5, 1, 1, 1, 32'(k), 1, 32'hA5);
    add(0, A_STAT, 0, 1, 1, 32'h600, 1, 0, 0, 0, 0, 0);
    add(1, A_STAT, 32'h400, 0, 1, 32'h600, 1, 0, 0, 0, 0, 0);
    add(0, A_STAT, 0, 0, 1, 32'h200, 1, 0, 0, 0, 0, 0);
    // Fill to full, then push and pop in the same cycle.
    for (int k = 0; k < 8; k++)
      add(1, A_FIFO, 32'h11 + 32'(k), 0, 0, 0, 1, (k > 0), (k > 0), 32'h11, 0, 0);
    add(0, A_STAT, 0, 0, 1, 32'h108, 1, 1, 1, 32'h11, 0, 0);
    add(1, A_FIFO, 32'h77, 1, 1, 32'd0, 1, 1, 1, 32'h11, 0, 0);
    add(0, A_STAT, 0, 0, 1, 32'h108, 1, 1, 1, 32'h12, 0, 0);
    for (int k = 2; k <= 8; k++)
      add(0, A_STAT, 0, 1, 0, 0, 1, 1, 1, 32'h10 + 32'(k), 0, 0);
    add(0, A_STAT, 0, 1, 1, 32'h001, 1, 1, 1, 32'h77, 0, 0);
    add(0, A_STAT, 0, 0, 1, 32'h200, 1, 0, 0, 0, 0, 0);
    // Three entries, then a long idle hold on FIFO_DATA (reads have no effect).
    for (int k = 0; k < 3; k++)
      add(1, A_FIFO, 32'hA + 32'(k), 0, 0, 0, 1, (k > 0), (k > 0), 32'hA, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, A_FIFO, 0, 0, 1, 32'd0, 1, 1, 1, 32'hA, 0, 0);
    add(0, A_STAT, 0, 0, 1, 32'h003, 1, 1, 1, 32'hA, 1, 32'hA5);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int rdy_pct;
    for (int i = 0; i < RW; i++) m_ram[i] = 32'd0;
    m_reset();
    build_table();

    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();

    // 1. Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].rdy);
      if (tbl[i].crd) chk("tbl_read_data", i, read_data, tbl[i].erd);
      if (tbl[i].cv)  chk("tbl_out_valid", i, {31'd0, out_valid}, {31'd0, tbl[i].ev});
      if (tbl[i].cd)  chk("tbl_out_data", i, out_data, tbl[i].ed);
      if (tbl[i].cg)  chk("tbl_gpio_out", i, gpio_out, tbl[i].eg);
      finish_cycle();
    end

    // 2. Reset mid-operation with three entries queued.
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 0, {31'd0, out_valid}, 32'd0);
    chk("rst_gpio_out", 0, gpio_out, 32'd0);
    drive(0, A_STAT, 0, 0);
    chk("rst_status", 0, read_data, 32'h200);
    drive(0, A_CYC, 0, 0);
    chk("rst_cycle", 0, read_data, 32'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 32'h110, 0, 0);
    chk("rst_ram_kept", 0, read_data, 32'hDEAD_BEEF);
    chk("rst_status_valid", 0, {31'd0, out_valid}, 32'd0);
    finish_cycle();
    drive(0, A_CYC, 0, 0);
    chk("rst_cycle_run", 0, read_data, 32'd1);
    finish_cycle();

    // 3. RAM fill, then randomized traffic against the model.
    for (int i = 0; i < RW; i++) begin
      drive(1, 32'(i * 4), $urandom, 0);
      finish_cycle();
    end
    rdy_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      int          sel;
      int          off;
      logic [31:0] a;
      logic [31:0] r;
      if (i % 200 == 0) rdy_pct = (rdy_pct == 20) ? 80 : 20;
      sel = int'($urandom_range(0, 9));
      r   = $urandom;
      if (sel < 4) begin
        a = r & 32'h7FFF_FFFF;
      end else begin
        off = (sel < 7) ? 2 : int'($urandom_range(0, 15));
        a = A_CYC | (32'(off) << 2) | (r & 32'h3);
      end
      drive($urandom_range(0, 1) == 1, a, $urandom,
            int'($urandom_range(0, 99)) < rdy_pct);
      chk("rnd_read_data", i, read_data, m_read(a));
      chk("rnd_out_valid", i, {31'd0, out_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
      if (m_q.size() > 0) chk("rnd_out_data", i, out_data, m_q[0]);
      chk("rnd_gpio_out", i, gpio_out, m_gpio);
      finish_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
